// File: rtl/missile_pool.sv
// missile_pool: pool of player missiles launched from the ship nose, moved upward each frame, retired at top or on hit
module missile_pool #(
   parameter int         N_MISSILES = 4,
   parameter int         STEP_Y     = 3,
   parameter int         SIZE_X     = 4,
   parameter int         SIZE_Y     = 6,
   parameter int         COOLDOWN   = 8,
   parameter logic [7:0] FIRE_KEY   = 8'h1A
) (
   input  logic                      frame_clk,
   input  logic                      Reset,
   input  logic [7:0]                keycode,
   input  logic [9:0]                ShipX,
   input  logic [9:0]                ShipY,
   input  logic [9:0]                Ship_sizeX,
   input  logic [N_MISSILES-1:0]     Hit,
   output logic [10*N_MISSILES-1:0]  MissileX,
   output logic [10*N_MISSILES-1:0]  MissileY,
   output logic [N_MISSILES-1:0]     MissileActive,
   output logic [9:0]                MissileSX,
   output logic [9:0]                MissileSY,
   output logic                      Fired,
   output logic                      Ready
);
   localparam logic [9:0] STEP   = 10'(STEP_Y);
   localparam logic [9:0] SX     = 10'(SIZE_X);
   localparam logic [9:0] SY     = 10'(SIZE_Y);
   localparam logic [9:0] HALF_X = 10'(SIZE_X >> 1);
   localparam logic [7:0] CD     = 8'(COOLDOWN);

   logic [N_MISSILES-1:0] active_q, active_d;
   logic [9:0]            x_q[N_MISSILES], x_d[N_MISSILES];
   logic [9:0]            y_q[N_MISSILES], y_d[N_MISSILES];
   logic [7:0]            cd_q, cd_d;
   logic                  fired_q, fired_d;
   logic                  launch, taken;
   logic [9:0]            launch_x, launch_y;

   assign launch_x = ShipX + (Ship_sizeX >> 1) - HALF_X;
   assign launch_y = ShipY - SY;
   assign launch   = (keycode == FIRE_KEY) && (cd_q == 8'd0) && !(&active_q) && (ShipY >= SY);
   assign Ready    = (cd_q == 8'd0) && !(&active_q);

   // Retire/move live slots; the lowest slot free before the edge takes a launch
   always_comb begin
      active_d = active_q;
      x_d      = x_q;
      y_d      = y_q;
      taken    = 1'b0;
      fired_d  = launch;
      cd_d     = launch ? CD : (cd_q == 8'd0 ? 8'd0 : cd_q - 8'd1);
      for (int i = 0; i < N_MISSILES; i++) begin
         if (active_q[i]) begin
            if (Hit[i] || y_q[i] <= STEP) active_d[i] = 1'b0;
            else y_d[i] = y_q[i] - STEP;
         end else if (launch && !taken) begin
            taken       = 1'b1;
            active_d[i] = 1'b1;
            x_d[i]      = launch_x;
            y_d[i]      = launch_y;
         end
      end
   end

   // Frame-rate state register with asynchronous clear
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         active_q <= '0;
         x_q      <= '{default: '0};
         y_q      <= '{default: '0};
         cd_q     <= 8'd0;
         fired_q  <= 1'b0;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
         cd_q     <= cd_d;
         fired_q  <= fired_d;
      end
   end

   for (genvar g = 0; g < N_MISSILES; g++) begin : g_pack
      assign MissileX[10*g +: 10] = x_q[g];
      assign MissileY[10*g +: 10] = y_q[g];
   end

   assign MissileActive = active_q;
   assign MissileSX     = SX;
   assign MissileSY     = SY;
   assign Fired         = fired_q;
endmodule

// File: tb/tb_missile_pool.sv
// tb_missile_pool: directed and randomized checks of missile_pool against a frame-level reference model
module tb_missile_pool;
   localparam int N = 4;

   logic           frame_clk = 1'b0;
   logic           Reset = 1'b0;
   logic [7:0]     keycode = 8'h00;
   logic [9:0]     ShipX = 10'd0, ShipY = 10'd0, Ship_sizeX = 10'd0;
   logic [N-1:0]   Hit = '0;
   logic [10*N-1:0] MissileX, MissileY;
   logic [N-1:0]   MissileActive;
   logic [9:0]     MissileSX, MissileSY;
   logic           Fired, Ready;

   int tests = 0;
   int fails = 0;

   logic [N-1:0] m_act;
   logic [9:0]   m_x[N], m_y[N];
   int           m_cd;
   logic         m_fired;

   missile_pool dut (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
      .ShipX(ShipX), .ShipY(ShipY), .Ship_sizeX(Ship_sizeX), .Hit(Hit),
      .MissileX(MissileX), .MissileY(MissileY), .MissileActive(MissileActive),
      .MissileSX(MissileSX), .MissileSY(MissileSY), .Fired(Fired), .Ready(Ready)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic model_clear();
      m_act = '0;
      m_cd = 0;
      m_fired = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_x[i] = 10'd0;
         m_y[i] = 10'd0;
      end
   endtask

   // One frame of the game rules, evaluated on the inputs about to be sampled
   task automatic model_step();
      int slot;
      bit go;
      slot = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
      go = (keycode == 8'h1A) && (m_cd == 0) && (slot >= 0) && (int'(ShipY) >= 6);
      for (int i = 0; i < N; i++)
         if (m_act[i]) begin
            if (Hit[i] || int'(m_y[i]) <= 3) m_act[i] = 1'b0;
            else m_y[i] = 10'((int'(m_y[i]) - 3) % 1024);
         end
      if (go) begin
         m_act[slot] = 1'b1;
         m_x[slot] = 10'((int'(ShipX) + int'(Ship_sizeX) / 2 - 2 + 1024) % 1024);
         m_y[slot] = 10'((int'(ShipY) - 6 + 1024) % 1024);
         m_cd = 8;
      end else if (m_cd > 0) m_cd = m_cd - 1;
      m_fired = go;
   endtask

   task automatic tick();
      model_step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      keycode = 8'h00;
      Hit = '0;
      model_clear();
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (MissileSX !== 10'd4 || MissileSY !== 10'd6) begin
         fails++;
         $display("FAIL reset_size: got %0d,%0d expected 4,6", MissileSX, MissileSY);
      end
      for (int f = 0; f < 5; f++) begin
         tick();
         tests++;
         if (MissileActive !== '0 || MissileX !== '0 || MissileY !== '0) begin
            fails++;
            $display("FAIL reset_idle f%0d: act=%b x=%h y=%h expected all zero", f, MissileActive, MissileX, MissileY);
         end
         tests++;
         if (Ready !== 1'b1 || Fired !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags f%0d: ready=%b fired=%b expected 1,0", f, Ready, Fired);
         end
      end
   endtask

   task automatic test_single_fire();
      int n;
      do_reset();
      ShipX = 10'd300; ShipY = 10'd400; Ship_sizeX = 10'd32; keycode = 8'h1A;
      tick();
      keycode = 8'h00;
      tests++;
      if (MissileActive !== 4'b0001 || MissileX[9:0] !== 10'd314 || MissileY[9:0] !== 10'd394 || Fired !== 1'b1) begin
         fails++;
         $display("FAIL single_launch: act=%b x=%0d y=%0d fired=%b expected 0001,314,394,1", MissileActive, MissileX[9:0], MissileY[9:0], Fired);
      end
      tick();
      tests++;
      if (MissileY[9:0] !== 10'd391 || Fired !== 1'b0) begin
         fails++;
         $display("FAIL single_move1: y=%0d fired=%b expected 391,0", MissileY[9:0], Fired);
      end
      tick();
      tests++;
      if (MissileY[9:0] !== 10'd388 || MissileX[9:0] !== 10'd314) begin
         fails++;
         $display("FAIL single_move2: x=%0d y=%0d expected 314,388", MissileX[9:0], MissileY[9:0]);
      end
      n = 0;
      while (MissileActive[0] === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      tests++;
      if (MissileActive[0] !== 1'b0 || MissileY[9:0] !== 10'd1 || MissileX[9:0] !== 10'd314) begin
         fails++;
         $display("FAIL single_retire: act=%b x=%0d y=%0d expected 0,314,1", MissileActive[0], MissileX[9:0], MissileY[9:0]);
      end
      tests++;
      if (n != 130) begin
         fails++;
         $display("FAIL single_retire_frame: retired after %0d more frames expected 130", n);
      end
   endtask

   task automatic test_cooldown_hold();
      int pulses;
      bit exp_f;
      do_reset();
      ShipX = 10'd300; ShipY = 10'd400; Ship_sizeX = 10'd32; keycode = 8'h1A;
      pulses = 0;
      for (int f = 0; f < 40; f++) begin
         tick();
         exp_f = (f == 0 || f == 9 || f == 18 || f == 27);
         if (Fired === 1'b1) pulses++;
         tests++;
         if (Fired !== exp_f) begin
            fails++;
            $display("FAIL hold_fired f%0d: got %b expected %b", f, Fired, exp_f);
         end
         if (f == 0 || f == 9 || f == 18 || f == 27) begin
            tests++;
            if (MissileActive !== 4'((1 << (f / 9 + 1)) - 1)) begin
               fails++;
               $display("FAIL hold_slot f%0d: act=%b", f, MissileActive);
            end
         end
         if (f == 36) begin
            tests++;
            if (MissileActive !== 4'b1111 || Ready !== 1'b0) begin
               fails++;
               $display("FAIL hold_full: act=%b ready=%b expected 1111,0", MissileActive, Ready);
            end
         end
      end
      tests++;
      if (pulses != 4) begin
         fails++;
         $display("FAIL hold_pulses: got %0d expected 4", pulses);
      end
   endtask

   task automatic test_hit_reuse();
      do_reset();
      ShipX = 10'd300; ShipY = 10'd400; Ship_sizeX = 10'd32; keycode = 8'h1A;
      for (int f = 0; f < 18; f++) tick();
      tests++;
      if (MissileActive !== 4'b0011 || Ready !== 1'b1) begin
         fails++;
         $display("FAIL hit_pre: act=%b ready=%b expected 0011,1", MissileActive, Ready);
      end
      Hit = 4'b0010;
      tick();
      Hit = '0;
      tests++;
      if (MissileActive !== 4'b0101 || Fired !== 1'b1 || MissileY[29:20] !== 10'd394) begin
         fails++;
         $display("FAIL hit_same_edge: act=%b fired=%b y2=%0d expected 0101,1,394", MissileActive, Fired, MissileY[29:20]);
      end
      for (int f = 0; f < 9; f++) tick();
      tests++;
      if (MissileActive !== 4'b0111 || Fired !== 1'b1 || MissileY[19:10] !== 10'd394 || MissileX[19:10] !== 10'd314) begin
         fails++;
         $display("FAIL hit_reuse: act=%b fired=%b x1=%0d y1=%0d expected 0111,1,314,394", MissileActive, Fired, MissileX[19:10], MissileY[19:10]);
      end
   endtask

   task automatic test_low_ship();
      do_reset();
      ShipX = 10'd100; ShipY = 10'd4; Ship_sizeX = 10'd20; keycode = 8'h1A;
      for (int f = 0; f < 12; f++) begin
         tick();
         tests++;
         if (Fired !== 1'b0 || MissileActive !== '0 || Ready !== 1'b1) begin
            fails++;
            $display("FAIL low_ship f%0d: fired=%b act=%b ready=%b expected 0,0000,1", f, Fired, MissileActive, Ready);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      ShipX = 10'd200; ShipY = 10'd300; Ship_sizeX = 10'd16; keycode = 8'h1A;
      for (int f = 0; f < 19; f++) tick();
      tests++;
      if (MissileActive !== 4'b0111 || Fired !== 1'b1) begin
         fails++;
         $display("FAIL async_pre: act=%b fired=%b expected 0111,1", MissileActive, Fired);
      end
      #2;
      Reset = 1'b1;
      #1;
      tests++;
      if (MissileActive !== '0 || MissileX !== '0 || MissileY !== '0 || Fired !== 1'b0 || Ready !== 1'b1) begin
         fails++;
         $display("FAIL async_clear: act=%b x=%h y=%h fired=%b ready=%b expected zeros, ready 1", MissileActive, MissileX, MissileY, Fired, Ready);
      end
      #1;
      Reset = 1'b0;
      model_clear();
      tick();
      tests++;
      if (MissileActive !== 4'b0001 || Fired !== 1'b1 || MissileX[9:0] !== 10'd206 || MissileY[9:0] !== 10'd294) begin
         fails++;
         $display("FAIL async_relaunch: act=%b fired=%b x=%0d y=%0d expected 0001,1,206,294", MissileActive, Fired, MissileX[9:0], MissileY[9:0]);
      end
   endtask

   task automatic test_random();
      int bad;
      do_reset();
      for (int f = 0; f < 400; f++) begin
         keycode = ($urandom_range(0, 3) != 0) ? 8'h1A : 8'($urandom);
         ShipX = 10'($urandom_range(0, 600));
         ShipY = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 8)) : 10'($urandom_range(6, 479));
         Ship_sizeX = 10'($urandom_range(4, 64));
         Hit = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         tick();
         bad = 0;
         for (int i = 0; i < N; i++)
            if (MissileActive[i] !== m_act[i] || MissileX[10*i +: 10] !== m_x[i] || MissileY[10*i +: 10] !== m_y[i]) bad++;
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL rand_slots f%0d: act=%b exp_act=%b x=%h y=%h", f, MissileActive, m_act, MissileX, MissileY);
         end
         tests++;
         if (Fired !== m_fired || Ready !== (m_cd == 0 && m_act != 4'b1111)) begin
            fails++;
            $display("FAIL rand_flags f%0d: fired=%b exp=%b ready=%b cd=%0d", f, Fired, m_fired, Ready, m_cd);
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single_fire();
      test_cooldown_hold();
      test_hit_reuse();
      test_low_ship();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
